rf_commit_ctrl: RTL
===================

RF_COMMIT_CTRL -- requirements
Module: rf_commit_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data width.
REQ-002 Parameter REG_CNT_WIDTH, default 5, register index width.
REQ-003 Parameter ROB_SIZE_WIDTH, default 3, ROB index width; ROB depth is 2^ROB_SIZE_WIDTH.
REQ-004 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port halt  in  1  freezes commit decisions while high.
REQ-007 Port rob_head_valid  in  1  ROB entry at head exists.
REQ-008 Port rob_head_done  in  1  head entry result is available.
REQ-009 Port rob_head_kind  in  2  00 reg-write, 01 store, 10 branch, 11 reserved (treated as reg-write).
REQ-010 Port rob_head_rd  in  REG_CNT_WIDTH  head destination register.
REQ-011 Port rob_head_val  in  XLEN  head result value.
REQ-012 Port rob_head_mispredict  in  1  branch at head was mispredicted.
REQ-013 Port rob_head_target  in  XLEN  correct PC for a mispredicted branch.
REQ-014 Port st_commit_ack  in  1  LSB has accepted the store commit.
REQ-015 Port rob_rf_ready  out  1  register file write strobe.
REQ-016 Port rob_rf_rd  out  REG_CNT_WIDTH  register file write index.
REQ-017 Port rob_rf_val  out  XLEN  register file write data.
REQ-018 Port rob_head_id  out  ROB_SIZE_WIDTH  current ROB head pointer.
REQ-019 Port st_commit_valid  out  1  store commit request to the LSB.
REQ-020 Port st_commit_id  out  ROB_SIZE_WIDTH  ROB id of the committing store.
REQ-021 Port flush  out  1  pipeline flush pulse.
REQ-022 Port flush_pc  out  XLEN  redirect PC accompanying flush.
REQ-023 Port commit_cnt  out  32  count of retired instructions.

Function
REQ-024 All outputs are registered.
REQ-025 The FSM has three states, RUN, WAIT_ST and FLUSH.
REQ-026 A head is committable in RUN when rob_head_valid && rob_head_done && !halt.
REQ-027 Reg-write commit: on the commit edge, rob_rf_ready <= (rob_head_rd != 0), rob_rf_rd/rob_rf_val <= head fields, rob_head_id increments, and commit_cnt increments.
REQ-028 rob_rf_ready is a single-cycle pulse; it is low on every cycle without a new reg-write commit, and back-to-back commits produce consecutive pulses.
REQ-029 Store at a committable head: st_commit_valid <= 1, st_commit_id <= rob_head_id, and the FSM goes to WAIT_ST; the head does not advance.
REQ-030 WAIT_ST: st_commit_valid holds at 1 until st_commit_ack is sampled high. On that edge, st_commit_valid <= 0, rob_head_id increments, commit_cnt increments, and the FSM returns to RUN. halt is ignored in WAIT_ST.
REQ-031 Correctly predicted branch: rob_head_id increments and commit_cnt increments; there is no RF write and no flush.
REQ-032 Mispredicted branch: flush <= 1, flush_pc <= rob_head_target, rob_head_id <= 0, commit_cnt increments, and the FSM goes to FLUSH.
REQ-033 FLUSH lasts exactly one cycle. flush <= 0 on exit, and the FSM returns to RUN; no commit is evaluated in this cycle.
REQ-034 rob_head_id increments modulo 2^ROB_SIZE_WIDTH, so (2^W)-1 wraps to 0.
REQ-035 commit_cnt wraps modulo 2^32.
REQ-036 Only one retirement occurs per cycle.
REQ-037 flush and rob_rf_ready are never high in the same cycle.
REQ-038 halt high in RUN: no state, pointer or counter change; outputs other than pulses hold their values.

Reset
REQ-039 While rst_n is low, asynchronously: the FSM is RUN, rob_head_id=0, commit_cnt=0, and rob_rf_ready, st_commit_valid and flush are 0.
REQ-040 While rst_n is low, asynchronously: rob_rf_rd=0, rob_rf_val=0, st_commit_id=0 and flush_pc=0.
REQ-041 Reset asserted in WAIT_ST or FLUSH abandons the operation; no ack is expected after release.
REQ-042 Reset is released synchronously to clk by the system; the first commit may occur on the first edge after release.

Verification
REQ-043 Reg commit, rd=5, val=0xDEADBEEF, head_id=0 -> the next cycle shows rob_rf_ready=1, rd=5, val=0xDEADBEEF, head_id=1, commit_cnt=1, and one cycle later rob_rf_ready=0.
REQ-044 Reg commit with rd=0 -> rob_rf_ready stays 0, head_id advances by 1, and commit_cnt increments.
REQ-045 Store at head_id=2, with ack held low for 3 cycles -> st_commit_valid=1 with id=2 for all 4 cycles and head_id stays 2; on the edge where ack=1 is sampled, head_id becomes 3.
REQ-046 Mispredict at head_id=4 with target 0x1000 -> flush=1 with flush_pc=0x1000 for exactly one cycle, head_id=0, and no commit during FLUSH.
REQ-047 Eight consecutive reg commits starting from head_id=6 with W=3 -> head_id sequence 7,0,1,...,6, and rob_rf_ready stays high for 8 consecutive cycles.
REQ-048 rst_n driven low mid-WAIT_ST -> all outputs are 0 immediately without a clock edge, and the FSM is in RUN after release.

Source files
------------

// File: rtl/rf_commit_ctrl.sv
// rf_commit_ctrl: in-order ROB commit controller.
// Retires at most one ROB head entry per cycle. It can do one of three things:
//   - write the result to the register file (reg-write, reserved kind),
//   - hand the store off to the LSB and wait for its ack (store),
//   - retire a branch, flushing the pipeline on a mispredict (branch).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   halt                    freezes commit decisions in RUN
//   rob_head_*              head entry: valid/done/kind/rd/val/mispredict/target
//   st_commit_ack           LSB accepted the store commit
//   rob_rf_ready/rd/val     register file write port (ready is a 1-cycle strobe)
//   rob_head_id             current ROB head pointer
//   st_commit_valid/id      store commit request to the LSB
//   flush/flush_pc          1-cycle flush pulse with redirect PC
//   commit_cnt              retired instruction count (wraps at 2^32)
// All outputs come straight from registers.
module rf_commit_ctrl #(
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5,
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      halt,
  input  logic                      rob_head_valid,
  input  logic                      rob_head_done,
  input  logic [1:0]                rob_head_kind,
  input  logic [REG_CNT_WIDTH-1:0]  rob_head_rd,
  input  logic [XLEN-1:0]           rob_head_val,
  input  logic                      rob_head_mispredict,
  input  logic [XLEN-1:0]           rob_head_target,
  input  logic                      st_commit_ack,
  output logic                      rob_rf_ready,
  output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  output logic [XLEN-1:0]           rob_rf_val,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic                      st_commit_valid,
  output logic [ROB_SIZE_WIDTH-1:0] st_commit_id,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc,
  output logic [31:0]               commit_cnt
);

  typedef enum logic [1:0] {RUN, WAIT_ST, FLUSH} state_e;

  localparam logic [1:0] KIND_STORE  = 2'b01;
  localparam logic [1:0] KIND_BRANCH = 2'b10;

  state_e                    state_q, state_d;
  logic                      rf_ready_q, rf_ready_d;
  logic [REG_CNT_WIDTH-1:0]  rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]           rf_val_q, rf_val_d;
  logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
  logic                      st_vld_q, st_vld_d;
  logic [ROB_SIZE_WIDTH-1:0] st_id_q, st_id_d;
  logic                      flush_q, flush_d;
  logic [XLEN-1:0]           flush_pc_q, flush_pc_d;
  logic [31:0]               cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    rf_ready_d = 1'b0;     // strobe: only high on the edge of a reg-write commit
    rf_rd_d    = rf_rd_q;
    rf_val_d   = rf_val_q;
    head_d     = head_q;
    st_vld_d   = st_vld_q;
    st_id_d    = st_id_q;
    flush_d    = 1'b0;     // pulse: only high on the mispredict edge
    flush_pc_d = flush_pc_q;
    cnt_d      = cnt_q;
    case (state_q)
      RUN: begin
        if (rob_head_valid && rob_head_done && !halt) begin
          case (rob_head_kind)
            KIND_STORE: begin
              // Head stays put until the LSB acknowledges.
              st_vld_d = 1'b1;
              st_id_d  = head_q;
              state_d  = WAIT_ST;
            end
            KIND_BRANCH: begin
              cnt_d = cnt_q + 32'd1;
              if (rob_head_mispredict) begin
                flush_d    = 1'b1;
                flush_pc_d = rob_head_target;
                head_d     = '0;   // ROB is emptied by the flush
                state_d    = FLUSH;
              end else begin
                head_d = head_q + 1'b1;
              end
            end
            default: begin   // reg-write and reserved kind
              rf_ready_d = (rob_head_rd != '0);  // x0 is never written
              rf_rd_d    = rob_head_rd;
              rf_val_d   = rob_head_val;
              head_d     = head_q + 1'b1;
              cnt_d      = cnt_q + 32'd1;
            end
          endcase
        end
      end
      WAIT_ST: begin
        // halt deliberately ignored: the LSB handshake must complete.
        if (st_commit_ack) begin
          st_vld_d = 1'b0;
          head_d   = head_q + 1'b1;
          cnt_d    = cnt_q + 32'd1;
          state_d  = RUN;
        end
      end
      FLUSH: state_d = RUN;   // one dead cycle, nothing evaluated
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rf_ready_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_val_q   <= '0;
      head_q     <= '0;
      st_vld_q   <= 1'b0;
      st_id_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rf_ready_q <= rf_ready_d;
      rf_rd_q    <= rf_rd_d;
      rf_val_q   <= rf_val_d;
      head_q     <= head_d;
      st_vld_q   <= st_vld_d;
      st_id_q    <= st_id_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rob_rf_ready    = rf_ready_q;
  assign rob_rf_rd       = rf_rd_q;
  assign rob_rf_val      = rf_val_q;
  assign rob_head_id     = head_q;
  assign st_commit_valid = st_vld_q;
  assign st_commit_id    = st_id_q;
  assign flush           = flush_q;
  assign flush_pc        = flush_pc_q;
  assign commit_cnt      = cnt_q;

endmodule
